// File: rtl/multi_rf_renamer_pkg.sv
// Shared types and helpers for the multi register-file renamer.
package multi_rf_renamer_pkg;

  localparam int DEF_NUM_RF      = 2;
  localparam int DEF_ARCH_REGS   = 32;
  localparam int DEF_PHYS_REGS   = 64;
  localparam int DEF_READ_PORTS  = 3;
  localparam int DEF_INUSE_DEPTH = 32;

  // Field widths of the in-use entry follow the default geometry.
  localparam int PHYS_ADDR_W = $clog2(DEF_PHYS_REGS);
  localparam int ARCH_ADDR_W = $clog2(DEF_ARCH_REGS);
  localparam int RF_IDX_W    = (DEF_NUM_RF > 1) ? $clog2(DEF_NUM_RF) : 1;

  typedef logic [PHYS_ADDR_W-1:0] phys_addr_t;

  typedef enum logic {ST_INIT, ST_RUN} init_state_e;

  // One renamed destination: which mapping it replaced and which it created.
  typedef struct packed {
    logic [RF_IDX_W-1:0]    rf;
    logic [ARCH_ADDR_W-1:0] rd;
    phys_addr_t             old_phys;
    phys_addr_t             new_phys;
  } renamer_inuse_entry_t;

  // Circular-buffer index advance for depths that need not be powers of two.
  function automatic int next_idx(input int idx, input int depth);
    return (idx == depth - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/multi_rf_renamer_free_list.sv
// Circular free list of physical registers for one register-file class.
// rollback un-pops the most recently popped entry.
module multi_rf_renamer_free_list
  import multi_rf_renamer_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PA_W  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [PA_W-1:0] push_phys,
  input  logic            pop,
  input  logic            rollback,
  output logic [PA_W-1:0] head,
  output logic            empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  // Entry storage written at the tail.
  // NOTE: storage arrays carry no reset; only the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_phys;
  end

  // Pointer and occupancy tracking; push and pop together leave count unchanged.
  // NOTE: state updates use <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(next_idx(int'(wr_ptr), DEPTH));
      if (pop)
        rd_ptr <= PTR_W'(next_idx(int'(rd_ptr), DEPTH));
      else if (rollback)
        rd_ptr <= (rd_ptr == '0) ? PTR_W'(DEPTH - 1) : rd_ptr - 1'b1;
      count <= count + CNT_W'(push) + CNT_W'(rollback) - CNT_W'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/multi_rf_renamer.sv
// Register renamer for several independent register-file classes, each with
// its own speculative map table and free list, sharing one in-use list.
module multi_rf_renamer
  import multi_rf_renamer_pkg::*;
#(
  parameter int              NUM_RF        = DEF_NUM_RF,
  parameter int              ARCH_REGS     = DEF_ARCH_REGS,
  parameter int              PHYS_REGS     = DEF_PHYS_REGS,
  parameter int              READ_PORTS    = DEF_READ_PORTS,
  parameter int              INUSE_DEPTH   = DEF_INUSE_DEPTH,
  parameter logic [NUM_RF-1:0] ZERO_REG_MASK = 2'b01,
  localparam int PA_W = $clog2(PHYS_REGS),
  localparam int AA_W = $clog2(ARCH_REGS),
  localparam int RF_W = (NUM_RF > 1) ? $clog2(NUM_RF) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       init_done,
  input  logic                       rename_req,
  input  logic [RF_W-1:0]            rename_rf,
  input  logic [AA_W-1:0]            rename_rd,
  output logic                       rename_ready,
  output logic [PA_W-1:0]            rename_phys_rd,
  input  logic [READ_PORTS*RF_W-1:0] rs_rf,
  input  logic [READ_PORTS*AA_W-1:0] rs_addr,
  output logic [READ_PORTS*PA_W-1:0] rs_phys,
  input  logic                       issue_commit,
  input  logic                       rollback,
  input  logic                       retire_valid,
  input  logic                       retire_discard,
  output logic                       inuse_full
);

  localparam int FL_DEPTH    = PHYS_REGS - ARCH_REGS;
  localparam int INIT_CYCLES = (ARCH_REGS > FL_DEPTH) ? ARCH_REGS : FL_DEPTH;
  localparam int INIT_W      = $clog2(INIT_CYCLES);
  localparam int IU_PTR_W    = (INUSE_DEPTH > 1) ? $clog2(INUSE_DEPTH) : 1;
  localparam int IU_CNT_W    = $clog2(INUSE_DEPTH + 1);

  init_state_e          state, state_next;
  logic [INIT_W-1:0]    init_cnt;
  logic                 run;

  logic [PA_W-1:0]      spec_table [NUM_RF][ARCH_REGS];
  logic [NUM_RF-1:0]    tbl_we;
  logic [AA_W-1:0]      tbl_waddr;
  logic [PA_W-1:0]      tbl_wdata;

  logic [NUM_RF-1:0]    fl_push, fl_pop, fl_unpop, fl_empty;
  logic [PA_W-1:0]      fl_push_phys;
  logic [PA_W-1:0]      fl_head [NUM_RF];

  renamer_inuse_entry_t prev_r;
  renamer_inuse_entry_t iu_mem [INUSE_DEPTH];
  renamer_inuse_entry_t iu_head;
  logic [IU_PTR_W-1:0]  iu_rd_ptr, iu_wr_ptr;
  logic [IU_CNT_W-1:0]  iu_count;

  logic init_tbl, init_fl;
  logic rename_zero, prev_zero, rename_fire;
  logic rollback_fire, retire_fire, discard_fire, iu_push;
  logic [PA_W-1:0] rename_old_phys;

  function automatic logic is_zero(input logic [RF_W-1:0] rf, input logic [AA_W-1:0] rd);
    return (rd == '0) && ZERO_REG_MASK[rf];
  endfunction

  // Init FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_INIT;
    else      state <= state_next;
  end

  // Init FSM next state: leave INIT once every table row and free slot is seeded.
  always_comb begin
    state_next = state;
    if (state == ST_INIT && int'(init_cnt) == INIT_CYCLES - 1) state_next = ST_RUN;
  end

  // Init FSM outputs.
  always_comb begin
    run       = (state == ST_RUN);
    init_done = run;
  end

  // Init sweep counter, restarted by every reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 init_cnt <= '0;
    else if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
  end

  assign init_tbl = (state == ST_INIT) && (int'(init_cnt) < ARCH_REGS);
  assign init_fl  = (state == ST_INIT) && (int'(init_cnt) < FL_DEPTH);

  assign iu_head         = iu_mem[iu_rd_ptr];
  assign inuse_full      = (int'(iu_count) == INUSE_DEPTH);
  assign rename_zero     = is_zero(rename_rf, rename_rd);
  assign prev_zero       = is_zero(prev_r.rf, prev_r.rd);
  assign rename_old_phys = spec_table[rename_rf][rename_rd];
  assign rename_ready    = run & ~rollback & ~(retire_valid & retire_discard)
                         & (rename_zero | ~fl_empty[rename_rf]);
  assign rename_phys_rd  = rename_zero ? '0 : fl_head[rename_rf];
  assign rename_fire     = rename_req & rename_ready;
  assign rollback_fire   = run & rollback & ~prev_zero;
  assign retire_fire     = run & retire_valid & (iu_count != '0);
  assign discard_fire    = retire_fire & retire_discard;
  assign iu_push         = run & issue_commit & ~prev_zero & ~inuse_full;

  // Free-list requests: init seeding, retire returns, rename pops, rollback un-pops.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    fl_push      = '0;
    fl_pop       = '0;
    fl_unpop     = '0;
    fl_push_phys = iu_head.old_phys;
    if (init_fl) begin
      fl_push      = '1;
      fl_push_phys = PA_W'(ARCH_REGS) + PA_W'(init_cnt);
    end else begin
      if (retire_fire) begin
        fl_push[iu_head.rf] = 1'b1;
        fl_push_phys        = retire_discard ? iu_head.new_phys : iu_head.old_phys;
      end
      if (rename_fire && !rename_zero) fl_pop[rename_rf] = 1'b1;
      if (rollback_fire)               fl_unpop[prev_r.rf] = 1'b1;
    end
  end

  for (genvar r = 0; r < NUM_RF; r++) begin : g_fl
    multi_rf_renamer_free_list #(.DEPTH(FL_DEPTH), .PA_W(PA_W)) u_fl (
      .clk       (clk),
      .rst       (rst),
      .push      (fl_push[r]),
      .push_phys (fl_push_phys),
      .pop       (fl_pop[r]),
      .rollback  (fl_unpop[r]),
      .head      (fl_head[r]),
      .empty     (fl_empty[r])
    );
  end

  // Single table write port, priority init > rollback > discard-retire > rename.
  always_comb begin
    tbl_we    = '0;
    tbl_waddr = rename_rd;
    tbl_wdata = rename_phys_rd;
    if (init_tbl) begin
      tbl_we    = '1;
      tbl_waddr = init_cnt[AA_W-1:0];
      tbl_wdata = PA_W'(init_cnt);
    end else if (rollback_fire) begin
      tbl_we[prev_r.rf] = 1'b1;
      tbl_waddr         = prev_r.rd;
      tbl_wdata         = prev_r.old_phys;
    end else if (discard_fire) begin
      tbl_we[iu_head.rf] = 1'b1;
      tbl_waddr          = iu_head.rd;
      tbl_wdata          = iu_head.old_phys;
    end else if (rename_fire && !rename_zero) begin
      tbl_we[rename_rf] = 1'b1;
    end
  end

  // Speculative map tables, one row set per class.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_RF; r++)
      if (tbl_we[r]) spec_table[r][tbl_waddr] <= tbl_wdata;
  end

  // Source lookups read pre-write contents; zero sources read as phys 0.
  always_comb begin
    rs_phys = '0;
    for (int p = 0; p < READ_PORTS; p++)
      if (!is_zero(rs_rf[p*RF_W +: RF_W], rs_addr[p*AA_W +: AA_W]))
        rs_phys[p*PA_W +: PA_W] = spec_table[rs_rf[p*RF_W +: RF_W]][rs_addr[p*AA_W +: AA_W]];
  end

  // Remember the mapping replaced by the latest accepted rename.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             prev_r <= '0;
    else if (rename_fire) prev_r <= '{rf: rename_rf, rd: rename_rd,
                                      old_phys: rename_old_phys, new_phys: rename_phys_rd};
  end

  // In-use list storage.
  always_ff @(posedge clk) begin
    if (iu_push) iu_mem[iu_wr_ptr] <= prev_r;
  end

  // In-use list pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iu_rd_ptr <= '0;
      iu_wr_ptr <= '0;
      iu_count  <= '0;
    end else begin
      if (iu_push)     iu_wr_ptr <= IU_PTR_W'(next_idx(int'(iu_wr_ptr), INUSE_DEPTH));
      if (retire_fire) iu_rd_ptr <= IU_PTR_W'(next_idx(int'(iu_rd_ptr), INUSE_DEPTH));
      iu_count <= iu_count + IU_CNT_W'(iu_push) - IU_CNT_W'(retire_fire);
    end
  end

  // Illegal request combinations from the surrounding pipeline.
  a_commit_full: assert property (@(posedge clk) disable iff (!rst)
    !(run && issue_commit && !prev_zero && inuse_full));
  a_rollback_discard: assert property (@(posedge clk) disable iff (!rst)
    !(run && rollback && retire_valid && retire_discard));

endmodule

// File: tb/tb_multi_rf_renamer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based reference model of the renamer.
module tb_multi_rf_renamer;

  localparam int NUM_RF = 2;
  localparam int ARCH   = 32;
  localparam int PHYS   = 64;
  localparam int RP     = 3;
  localparam int IU     = 32;
  localparam int PA_W   = 6;
  localparam int AA_W   = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 init_done;
  logic                 rename_req;
  logic [0:0]           rename_rf;
  logic [AA_W-1:0]      rename_rd;
  logic                 rename_ready;
  logic [PA_W-1:0]      rename_phys_rd;
  logic [RP-1:0]        rs_rf;
  logic [RP*AA_W-1:0]   rs_addr;
  logic [RP*PA_W-1:0]   rs_phys;
  logic                 issue_commit, rollback, retire_valid, retire_discard;
  logic                 inuse_full;

  always #5 clk = ~clk;

  multi_rf_renamer dut (
    .clk            (clk),
    .rst            (rst),
    .init_done      (init_done),
    .rename_req     (rename_req),
    .rename_rf      (rename_rf),
    .rename_rd      (rename_rd),
    .rename_ready   (rename_ready),
    .rename_phys_rd (rename_phys_rd),
    .rs_rf          (rs_rf),
    .rs_addr        (rs_addr),
    .rs_phys        (rs_phys),
    .issue_commit   (issue_commit),
    .rollback       (rollback),
    .retire_valid   (retire_valid),
    .retire_discard (retire_discard),
    .inuse_full     (inuse_full)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int rf;
    int rd;
    int old_p;
    int new_p;
  } mentry_t;

  logic [1:0] zmask = 2'b01;
  int         map_t [NUM_RF][ARCH];
  int         fl_q  [NUM_RF][$];
  mentry_t    iu_q  [$];
  mentry_t    prev_m;
  bit         pending;

  int rs_rf_a   [RP];
  int rs_addr_a [RP];

  bit cur_req, cur_com, cur_rb, cur_rv, cur_dis, exp_ready;
  int cur_rf, cur_rd;

  function automatic bit mzero(input int rf, input int rd);
    return (rd == 0) && zmask[rf];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NUM_RF; r++) begin
      for (int a = 0; a < ARCH; a++) map_t[r][a] = a;
      fl_q[r].delete();
      for (int p = ARCH; p < PHYS; p++) fl_q[r].push_back(p);
    end
    iu_q.delete();
    prev_m  = '{0, 0, 0, 0};
    pending = 1'b0;
  endtask

  task automatic clear_inputs();
    rename_req = 0; rename_rf = 0; rename_rd = 0; rs_rf = 0; rs_addr = 0;
    issue_commit = 0; rollback = 0; retire_valid = 0; retire_discard = 0;
  endtask

  task automatic rand_rs();
    for (int p = 0; p < RP; p++) begin
      rs_rf_a[p]   = $urandom_range(0, 1);
      rs_addr_a[p] = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, ARCH - 1);
    end
  endtask

  // Drive one cycle's inputs after the falling edge and compare outputs.
  task automatic apply(input bit req_i, input int rf_i, input int rd_i,
                       input bit com_i, input bit rb_i, input bit rv_i, input bit dis_i);
    bit z;
    @(negedge clk);
    rename_req     = req_i;
    rename_rf      = rf_i[0];
    rename_rd      = rd_i[AA_W-1:0];
    issue_commit   = com_i;
    rollback       = rb_i;
    retire_valid   = rv_i;
    retire_discard = dis_i;
    for (int p = 0; p < RP; p++) begin
      rs_rf[p]                 = rs_rf_a[p][0];
      rs_addr[p*AA_W +: AA_W]  = rs_addr_a[p][AA_W-1:0];
    end
    cur_req = req_i; cur_rf = rf_i; cur_rd = rd_i;
    cur_com = com_i; cur_rb = rb_i; cur_rv = rv_i; cur_dis = dis_i;
    #1;
    z         = mzero(rf_i, rd_i);
    exp_ready = !rb_i && !(rv_i && dis_i) && (z || fl_q[rf_i].size() > 0);
    check("init_done", init_done, 1);
    check("rename_ready", rename_ready, exp_ready);
    if (exp_ready) check("rename_phys_rd", rename_phys_rd, z ? 0 : fl_q[rf_i][0]);
    for (int p = 0; p < RP; p++)
      check("rs_phys", rs_phys[p*PA_W +: PA_W],
            mzero(rs_rf_a[p], rs_addr_a[p]) ? 0 : map_t[rs_rf_a[p]][rs_addr_a[p]]);
    check("inuse_full", inuse_full, iu_q.size() == IU);
  endtask

  // Advance through the rising edge and apply the renamer rules to the model.
  task automatic tick();
    mentry_t e;
    int      iu_before, p_new, old_p;
    bit      z;
    @(posedge clk);
    iu_before = iu_q.size();
    if (cur_rb && !mzero(prev_m.rf, prev_m.rd)) begin
      map_t[prev_m.rf][prev_m.rd] = prev_m.old_p;
      fl_q[prev_m.rf].push_front(prev_m.new_p);
    end
    if (cur_rv && iu_before > 0) begin
      e = iu_q.pop_front();
      if (cur_dis) begin
        fl_q[e.rf].push_back(e.new_p);
        map_t[e.rf][e.rd] = e.old_p;
      end else begin
        fl_q[e.rf].push_back(e.old_p);
      end
    end
    if (cur_com && !mzero(prev_m.rf, prev_m.rd) && iu_before < IU) iu_q.push_back(prev_m);
    if (cur_req && exp_ready) begin
      z     = mzero(cur_rf, cur_rd);
      p_new = z ? 0 : fl_q[cur_rf].pop_front();
      old_p = map_t[cur_rf][cur_rd];
      if (!z) map_t[cur_rf][cur_rd] = p_new;
      prev_m = '{cur_rf, cur_rd, old_p, p_new};
    end
    pending = cur_req && exp_ready && !mzero(cur_rf, cur_rd);
  endtask

  // Reset, optionally interrupt init after abort_at cycles, then time init.
  task automatic reset_and_init(input int abort_at);
    int n;
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #1;
    check("rst_init_done", init_done, 0);
    check("rst_rename_ready", rename_ready, 0);
    check("rst_inuse_full", inuse_full, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      #1;
      check("mid_init_done", init_done, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_init_done", init_done, 0);
      check("abort_rename_ready", rename_ready, 0);
      check("abort_inuse_full", inuse_full, 0);
      @(negedge clk);
      rst = 1'b1;
    end
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("init_cycles", n, 32);
    model_reset();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    model_reset();

    // Reset release and first lookups.
    reset_and_init(0);
    rand_rs(); rs_rf_a[0] = 1; rs_addr_a[0] = 5;
    apply(0, 0, 3, 0, 0, 0, 0);
    check("t1_rs_c1_r5", rs_phys[PA_W-1:0], 5);
    check("t1_grant_c0_r3", rename_phys_rd, 32);
    tick();

    // Two renames of the same rd, commit both, retire both.
    rand_rs();
    apply(1, 0, 3, 0, 0, 0, 0); check("t2_grant_a", rename_phys_rd, 32); tick();
    apply(1, 0, 3, 1, 0, 0, 0); check("t2_grant_b", rename_phys_rd, 33); tick();
    rs_rf_a[0] = 0; rs_addr_a[0] = 3;
    apply(0, 0, 0, 1, 0, 0, 0); check("t2_rs_r3", rs_phys[PA_W-1:0], 33); tick();
    apply(0, 0, 0, 0, 0, 1, 0); tick();
    apply(0, 0, 0, 0, 0, 1, 0); tick();

    // Drain class 0 free list, then recover with one retire.
    reset_and_init(0);
    for (int i = 0; i < 32; i++) begin
      rand_rs();
      apply(1, 0, (i % 31) + 1, i > 0, 0, 0, 0);
      tick();
    end
    apply(1, 0, 5, 1, 0, 0, 0); check("t3_ready_empty", rename_ready, 0); tick();
    apply(1, 0, 5, 0, 0, 1, 0); check("t3_inuse_full", inuse_full, 1); tick();
    apply(1, 0, 5, 0, 0, 0, 0);
    check("t3_ready_back", rename_ready, 1);
    check("t3_grant_returned", rename_phys_rd, 1);
    tick();

    // Rename then rollback.
    reset_and_init(0);
    rand_rs();
    apply(1, 0, 7, 0, 0, 0, 0); check("t4_grant", rename_phys_rd, 32); tick();
    apply(0, 0, 0, 0, 1, 0, 0); check("t4_ready_rollback", rename_ready, 0); tick();
    rs_rf_a[0] = 0; rs_addr_a[0] = 7;
    apply(1, 0, 9, 0, 0, 0, 0);
    check("t4_rs_r7", rs_phys[PA_W-1:0], 7);
    check("t4_regrant", rename_phys_rd, 32);
    tick();

    // Discard retire, then zero-register behaviour per class.
    reset_and_init(0);
    rand_rs();
    apply(1, 0, 4, 0, 0, 0, 0); check("t5_grant", rename_phys_rd, 32); tick();
    apply(0, 0, 0, 1, 0, 0, 0); tick();
    apply(1, 0, 6, 0, 0, 1, 1); check("t5_ready_discard", rename_ready, 0); tick();
    rs_rf_a[0] = 0; rs_addr_a[0] = 4;
    apply(1, 0, 0, 0, 0, 0, 0);
    check("t5_rs_r4", rs_phys[PA_W-1:0], 4);
    check("t5_zero_grant", rename_phys_rd, 0);
    check("t5_zero_ready", rename_ready, 1);
    tick();
    apply(1, 0, 5, 0, 0, 0, 0); check("t5_no_pop", rename_phys_rd, 33); tick();
    apply(1, 1, 0, 1, 0, 0, 0); check("t5_c1_r0_renamed", rename_phys_rd, 32); tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      bit req, com, rb, rv, dis;
      int rf, rd;
      rand_rs();
      com = 0; rb = 0;
      if (pending) begin
        if (iu_q.size() == IU || $urandom_range(0, 6) == 0) rb = 1;
        else com = 1;
      end
      rv  = (iu_q.size() > 0) && ($urandom_range(0, 2) == 0);
      dis = rv && !rb && ($urandom_range(0, 4) == 0);
      rf  = $urandom_range(0, 1);
      rd  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, ARCH - 1);
      req = ($urandom_range(0, 3) != 0);
      apply(req, rf, rd, com, rb, rv, dis);
      tick();
    end

    // Reset in the middle of init restarts the sweep.
    reset_and_init(10);
    rand_rs();
    apply(1, 0, 3, 0, 0, 0, 0); check("t6_grant_after_restart", rename_phys_rd, 32); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_rf_renamer.md
Name: multi_rf_renamer

Overview:
- Parametrised register renamer for NUM_RF independent register-file classes (e.g. GP, FP), each with its own spec table and free list.
- Sits between decode (rename, source lookup) and issue/retire (commit, rollback, discard).
- Over the single-purpose predecessor it adds:
  - a self-contained init state machine;
  - free-list-empty backpressure instead of assuming in-flight ≤ free registers;
  - a per-class zero-register mask.

Parameters:
NUM_RF, 2, number of register-file classes
ARCH_REGS, 32, architectural registers per class (power of 2)
PHYS_REGS, 64, physical registers per class (power of 2, > ARCH_REGS)
READ_PORTS, 3, source lookups per decode
INUSE_DEPTH, 32, in-flight renamed destinations (all classes)
ZERO_REG_MASK, 2'b01, bit r set = arch reg 0 of class r hardwired, never renamed

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
init_done  out  1  high once init FSM reaches RUN
rename_req  in  1  decode wants to rename rd this cycle
rename_rf  in  RF_W  class of rd
rename_rd  in  AA_W  architectural rd
rename_ready  out  1  rename accepted when rename_req & rename_ready
rename_phys_rd  out  PA_W  physical rd granted
rs_rf  in  READ_PORTS×RF_W  class per source
rs_addr  in  READ_PORTS×AA_W  architectural sources
rs_phys  out  READ_PORTS×PA_W  current speculative mapping
issue_commit  in  1  renamed instruction leaves issue; record in in-use list
rollback  in  1  renamed instruction in issue is flushed
retire_valid  in  1  pop oldest in-use entry
retire_discard  in  1  with retire_valid: instruction squashed
inuse_full  out  1  in-use list full

Behaviour:
- Widths:
  - PA_W=$clog2(PHYS_REGS)
  - AA_W=$clog2(ARCH_REGS)
  - RF_W=max(1,$clog2(NUM_RF))
- Reset (rst=0, async):
  - FSM→INIT, init counter=0.
  - Free-list and in-use pointers/counts=0; prev_r cleared.
  - init_done=0, rename_ready=0, inuse_full=0.
  - Spec tables are not reset.
- Init state machine:
  - INIT: for counter i = 0..ARCH_REGS−1, one per cycle, write table[r][i]=i for every class r.
  - INIT, same cycles: push phys ARCH_REGS+i to every class free list while i < PHYS_REGS−ARCH_REGS.
  - After max(ARCH_REGS, PHYS_REGS−ARCH_REGS) cycles (32 at defaults), go to RUN and set init_done=1.
  - All other inputs are ignored in INIT.
- Zero register:
  - A "zero rd" is rd==0 in a class whose ZERO_REG_MASK bit is set.
  - Zero rd: rename_phys_rd=0, no free-list pop, no table write, not pushed to in-use.
  - rs_phys for a zero source is 0.
- rename_ready:
  - rename_ready = RUN & ~rollback & ~(retire_valid & retire_discard) & (zero rd | free list of rename_rf non-empty).
  - rename_phys_rd = free-list head, combinational, same cycle.
- Rename accept: pop the free list, write table[rf][rd]=head, and latch the prior mapping {rf, rd, old phys, new phys} into prev_r.
- Source lookup:
  - rs_phys is a combinational read of pre-write table contents; the instruction's own rd is not forwarded.
  - The next cycle sees the new mapping.
- issue_commit: push prev_r to in-use list. Unless prev_r holds a zero rd, issue_commit with inuse_full is illegal (assertion).
- rollback:
  - Write table[prev_r.rf][prev_r.rd]=prev_r.old.
  - Un-pop that class free list (read pointer −1).
  - No effect if prev_r is a zero rd.
- retire_valid & ~retire_discard: push entry.old to its class free list.
- retire_valid & retire_discard: push entry.new to its free list and restore table[rf][rd]=entry.old.
- Table write-port priority: init > rollback > discard-retire > rename.
- rollback with discard-retire in the same cycle is illegal (assertion).
- Free-list push and pop in the same cycle: count unchanged, both pointers wrap modulo PHYS_REGS−ARCH_REGS.
- Reset asserted mid-INIT restarts init from counter 0.

Decomposition:
- Shared package cva5_types gets:
  - renamer_inuse_entry_t {rf, rd, old_phys, new_phys};
  - phys_addr width constant derived from PHYS_REGS.
- Sub-module: existing register_free_list, one instance per class via generate; its rollback input is the un-pop.
- In-use list is an existing cva5_fifo.
- Spec tables use lutram_1w_mr, with READ_PORTS+1 read ports (extra port for prev lookup).

Test Plan:
- Reset release: init_done rises exactly 32 cycles after rst deasserts; then rs_phys for class 1 rs=5 equals 5, and rename_phys_rd for class 0 rd=3 is 32.
- Rename class 0 rd=3 twice, commit both: grants 32 then 33; lookup rs=3 gives 33. Retire both non-discard: phys 3 and 32 return to the free list tail.
- 32 class-0 renames without retire: the 33rd cycle shows rename_ready=0. One retire → rename_ready=1 next cycle, granting the returned phys.
- Rename rd=7 (gets 32), then rollback: rs=7 reads 7 again and the next rename grants 32 again.
- Rename rd=4 →32, commit, retire_discard: rs=4 reads 4 and 32 is re-queued. Class 0 rd=0: phys 0, no pop. Class 1 rd=0: renamed normally.
- Pull rst low at init cycle 10: all outputs return to reset values; init restarts and completes 32 cycles after release.
